mac_array_acc: RTL and testbench
================================

MAC_ARRAY_ACC -- requirements
Module: mac_array_acc

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_LANES, 4, parallel multiply lanes per beat
  LEN_DATA_IN, 8, signed data width per lane
  LEN_WEIGHT, 8, signed weight width per lane
  LEN_DATA_OUT, 20, signed accumulator/output width; SHALL be >= LEN_DATA_IN+LEN_WEIGHT+clog2(NUM_LANES)
  LEN_CNT, 8, width of vector-length input
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  CLK  in  1  single clock, rising edge
  SYNC_RST_B  in  1  reset, synchronous, active-low
  IN_VALID  in  1  input beat offered
  IN_READY  out  1  input beat accepted when IN_VALID&IN_READY
  DATA_IN  in  NUM_LANES*LEN_DATA_IN  packed signed data, lane 0 in LSBs
  WEIGHT_INPUT  in  NUM_LANES*LEN_WEIGHT  packed signed weights, lane 0 in LSBs
  ACC_LEN  in  LEN_CNT  beats per output vector, sampled on first beat
  SAT_EN  in  1  1 = saturate, 0 = wrap, sampled on first beat
  CLR  in  1  abort partial vector
  OUT_VALID  out  1  result available
  OUT_READY  in  1  result consumed when OUT_VALID&OUT_READY
  DATA_OUT  out  LEN_DATA_OUT  signed accumulated result
  OUT_SAT  out  1  overflow occurred in this vector

Function
REQ-003 Beat sum SHALL be the full-precision signed sum of NUM_LANES products DATA_IN[i]*WEIGHT_INPUT[i]; no truncation before accumulation.
REQ-004 FSM states SHALL be IDLE (no partial vector) and ACCUM (partial vector held); IDLE->ACCUM on accepted first beat when effective length >1; ACCUM->IDLE on accepted last beat or CLR.
REQ-005 Effective length SHALL be ACC_LEN, with ACC_LEN=0 treated as 1; a beat counter SHALL count accepted beats and wrap to 0 on the last beat.
REQ-006 Each accepted beat SHALL update ACC <= ACC + beat_sum, computed one bit wider than LEN_DATA_OUT, then clamped to [-2^(LEN_DATA_OUT-1), 2^(LEN_DATA_OUT-1)-1] if SAT_EN, else wrapped modulo 2^LEN_DATA_OUT.
REQ-007 A sticky overflow bit SHALL be set when any step of the vector exceeds the range, regardless of SAT_EN.
REQ-008 On the last beat: DATA_OUT <= final ACC value, OUT_SAT <= sticky bit (including that step), OUT_VALID <= 1, ACC and sticky bit <= 0; latency 1 cycle after the last accepted beat.
REQ-009 IN_READY SHALL equal (!OUT_VALID | OUT_READY) & !CLR; a last beat and an output handshake in the same cycle SHALL both complete, DATA_OUT taking the new result.
REQ-010 OUT_VALID SHALL clear on handshake unless a new result loads in that cycle; DATA_OUT and OUT_SAT SHALL hold stable while OUT_VALID & !OUT_READY.
REQ-011 CLR SHALL zero ACC, counter and sticky bit and force IDLE; it SHALL NOT affect a pending DATA_OUT/OUT_VALID; CLR wins over a simultaneous IN_VALID.
REQ-012 ACC_LEN/SAT_EN changes mid-vector SHALL be ignored until the next first beat.

Reset
REQ-013 On a CLK edge with SYNC_RST_B=0: state IDLE, ACC, counter, sticky bit, DATA_OUT, OUT_SAT and OUT_VALID SHALL be 0; reset SHALL take priority over all inputs, including mid-vector.
REQ-014 IN_READY SHALL be 1 in the first cycle after reset release (OUT_VALID=0, CLR=0).

Structure
REQ-015 Shared package mac_pkg SHALL hold default parameter constants and the FSM state enum (IDLE, ACCUM).
REQ-016 One sub-module mac_sat_add SHALL implement the wide add, range check, clamp/wrap and overflow flag of REQ-006/007.

Verification (NUM_LANES=4, 8/8/20 bits)
REQ-017 Reset: SYNC_RST_B=0 for 2 cycles mid-stream -> next cycle OUT_VALID=0, DATA_OUT=0, OUT_SAT=0, IN_READY=1.
REQ-018 ACC_LEN=3, all lanes DATA_IN=-125, WEIGHT_INPUT=3, 3 beats -> DATA_OUT=-4500, OUT_SAT=0, OUT_VALID 1 cycle after third beat.
REQ-019 ACC_LEN=10, all lanes 127x127 (64516/beat), SAT_EN=1 -> DATA_OUT=524287, OUT_SAT=1; SAT_EN=0 -> DATA_OUT=-403416, OUT_SAT=1.
REQ-020 OUT_READY=0 with result pending -> IN_READY=0, DATA_OUT stable 5 cycles; OUT_READY=1 with last beat of next vector in same cycle -> both handshakes, new result next cycle.
REQ-021 ACC_LEN=4, CLR after 2 beats, then 4 beats of lanes 1x1 -> DATA_OUT=16, no contribution from pre-CLR beats.
REQ-022 ACC_LEN=0, single beat lanes 2x-3 -> DATA_OUT=-24, OUT_VALID next cycle.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared constants and FSM state type for the MAC array accumulator.
package mac_pkg;

  localparam int MAC_NUM_LANES    = 4;
  localparam int MAC_LEN_DATA_IN  = 8;
  localparam int MAC_LEN_WEIGHT   = 8;
  localparam int MAC_LEN_DATA_OUT = 20;
  localparam int MAC_LEN_CNT      = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } mac_state_e;

  // Width needed to hold the exact signed sum of all lane products in one beat.
  function automatic int sum_width(input int lanes, input int dw, input int ww);
    return dw + ww + $clog2(lanes);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Accumulator step: one-bit-wider signed add with saturate-or-wrap and overflow flag.
module mac_sat_add #(
  parameter int W = 20
) (
  input  logic signed [W-1:0] acc,
  input  logic signed [W-1:0] addend,
  input  logic                sat_en,
  output logic signed [W-1:0] result,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [W:0] wide;

  // Add with a guard bit; a guard/MSB disagreement means the true sum left the W-bit range.
  always_comb begin
    wide   = {acc[W-1], acc} + {addend[W-1], addend};
    ovf    = wide[W] ^ wide[W-1];
    result = wide[W-1:0];
    if (ovf && sat_en) begin
      result = wide[W] ? MIN_VAL : MAX_VAL;
    end
  end

endmodule

// File: rtl/mac_array_acc.sv
// Multi-lane signed multiply-accumulate over a vector of beats with a
// single-entry registered result and valid/ready handshakes on both sides.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no partial vector; next accepted beat is a first beat
// ACCUM | partial vector held in acc_q; length/saturation mode latched
module mac_array_acc
  import mac_pkg::*;
#(
  parameter int NUM_LANES    = MAC_NUM_LANES,
  parameter int LEN_DATA_IN  = MAC_LEN_DATA_IN,
  parameter int LEN_WEIGHT   = MAC_LEN_WEIGHT,
  parameter int LEN_DATA_OUT = MAC_LEN_DATA_OUT,
  parameter int LEN_CNT      = MAC_LEN_CNT
) (
  input  logic                                CLK,
  input  logic                                SYNC_RST_B,
  input  logic                                IN_VALID,
  output logic                                IN_READY,
  input  logic [NUM_LANES*LEN_DATA_IN-1:0]    DATA_IN,
  input  logic [NUM_LANES*LEN_WEIGHT-1:0]     WEIGHT_INPUT,
  input  logic [LEN_CNT-1:0]                  ACC_LEN,
  input  logic                                SAT_EN,
  input  logic                                CLR,
  output logic                                OUT_VALID,
  input  logic                                OUT_READY,
  output logic signed [LEN_DATA_OUT-1:0]      DATA_OUT,
  output logic                                OUT_SAT
);

  localparam int SUM_W  = sum_width(NUM_LANES, LEN_DATA_IN, LEN_WEIGHT);
  localparam int PROD_W = LEN_DATA_IN + LEN_WEIGHT;

  mac_state_e state_q, state_nxt;

  logic signed [LEN_DATA_OUT-1:0] acc_q;
  logic [LEN_CNT-1:0]             cnt_q;
  logic                           sticky_q;
  logic [LEN_CNT-1:0]             len_q;
  logic                           sat_q;

  logic signed [LEN_DATA_IN-1:0]  d_lane;
  logic signed [LEN_WEIGHT-1:0]   w_lane;
  logic signed [PROD_W-1:0]       prod;
  logic signed [SUM_W-1:0]        beat_sum_full;
  logic signed [LEN_DATA_OUT-1:0] beat_sum;

  logic                           accept;
  logic                           last_beat;
  logic [LEN_CNT-1:0]             eff_len;
  logic                           sat_eff;
  logic signed [LEN_DATA_OUT-1:0] acc_sum;
  logic                           step_ovf;

  // Exact sum of all lane products, sign-extended to the accumulator width.
  always_comb begin
    d_lane        = '0;
    w_lane        = '0;
    prod          = '0;
    beat_sum_full = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      d_lane        = DATA_IN[i*LEN_DATA_IN +: LEN_DATA_IN];
      w_lane        = WEIGHT_INPUT[i*LEN_WEIGHT +: LEN_WEIGHT];
      prod          = d_lane * w_lane;
      beat_sum_full = beat_sum_full + SUM_W'(prod);
    end
    beat_sum = LEN_DATA_OUT'(beat_sum_full);
  end

  mac_sat_add #(
    .W (LEN_DATA_OUT)
  ) u_sat_add (
    .acc    (acc_q),
    .addend (beat_sum),
    .sat_en (sat_eff),
    .result (acc_sum),
    .ovf    (step_ovf)
  );

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!SYNC_RST_B) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next state: CLR aborts, otherwise an accepted beat opens or closes a vector.
  always_comb begin
    state_nxt = state_q;
    if (CLR) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = last_beat ? IDLE : ACCUM;
    end
  end

  // FSM outputs: handshake and the per-vector controls (live on a first beat, latched after).
  always_comb begin
    IN_READY  = (!OUT_VALID || OUT_READY) && !CLR;
    accept    = IN_VALID && IN_READY;
    if (state_q == IDLE) begin
      eff_len = (ACC_LEN == '0) ? LEN_CNT'(1) : ACC_LEN;
      sat_eff = SAT_EN;
    end else begin
      eff_len = len_q;
      sat_eff = sat_q;
    end
    last_beat = accept && (cnt_q == eff_len - LEN_CNT'(1));
  end

  // Accumulator, beat counter, sticky overflow and latched vector controls.
  always_ff @(posedge CLK) begin
    if (!SYNC_RST_B) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      len_q    <= '0;
      sat_q    <= 1'b0;
    end else if (CLR) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        len_q <= eff_len;
        sat_q <= SAT_EN;
      end
      if (last_beat) begin
        acc_q    <= '0;
        cnt_q    <= '0;
        sticky_q <= 1'b0;
      end else begin
        acc_q    <= acc_sum;
        cnt_q    <= cnt_q + LEN_CNT'(1);
        sticky_q <= sticky_q | step_ovf;
      end
    end
  end

  // Result register: a new result loads even while the old one is being consumed.
  always_ff @(posedge CLK) begin
    if (!SYNC_RST_B) begin
      DATA_OUT  <= '0;
      OUT_SAT   <= 1'b0;
      OUT_VALID <= 1'b0;
    end else if (last_beat) begin
      DATA_OUT  <= acc_sum;
      OUT_SAT   <= sticky_q | step_ovf;
      OUT_VALID <= 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_array_acc.sv
// Directed scoreboard bench for mac_array_acc (4 lanes, 8/8/20 bits).
module tb_mac_array_acc;

  logic        CLK;
  logic        SYNC_RST_B;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] DATA_IN;
  logic [31:0] WEIGHT_INPUT;
  logic [7:0]  ACC_LEN;
  logic        SAT_EN;
  logic        CLR;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic signed [19:0] DATA_OUT;
  logic        OUT_SAT;

  typedef struct {
    longint data;
    bit     sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mac_array_acc dut (
    .CLK          (CLK),
    .SYNC_RST_B   (SYNC_RST_B),
    .IN_VALID     (IN_VALID),
    .IN_READY     (IN_READY),
    .DATA_IN      (DATA_IN),
    .WEIGHT_INPUT (WEIGHT_INPUT),
    .ACC_LEN      (ACC_LEN),
    .SAT_EN       (SAT_EN),
    .CLR          (CLR),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .DATA_OUT     (DATA_OUT),
    .OUT_SAT      (OUT_SAT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push_exp(input longint d, input bit s);
    exp_t e;
    e.data = d;
    e.sat  = s;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Offer one beat with every lane carrying d x w; returns 1 ns after the accepting edge.
  task automatic beat(input int d, input int w);
    logic [7:0] db;
    logic [7:0] wb;
    db           = d[7:0];
    wb           = w[7:0];
    DATA_IN      = {4{db}};
    WEIGHT_INPUT = {4{wb}};
    IN_VALID     = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge CLK);
      if (IN_READY) begin
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        return;
      end
      @(posedge CLK);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL beat_accept: got no IN_READY within 50 cycles, expected acceptance");
    IN_VALID = 1'b0;
  endtask

  // Monitor: every output handshake pops one expected result.
  always @(negedge CLK) begin
    if (SYNC_RST_B && OUT_VALID && OUT_READY) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got result %0d with empty queue, expected none", DATA_OUT);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_data", longint'(DATA_OUT), e.data);
        chk("sb_sat", longint'(OUT_SAT), longint'(e.sat));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    SYNC_RST_B   = 1'b0;
    IN_VALID     = 1'b0;
    DATA_IN      = '0;
    WEIGHT_INPUT = '0;
    ACC_LEN      = 8'd0;
    SAT_EN       = 1'b0;
    CLR          = 1'b0;
    OUT_READY    = 1'b1;
    idle(3);
    SYNC_RST_B = 1'b1;
    chk("rst_out_valid", longint'(OUT_VALID), 0);
    chk("rst_data_out", longint'(DATA_OUT), 0);
    chk("rst_out_sat", longint'(OUT_SAT), 0);
    chk("rst_in_ready", longint'(IN_READY), 1);

    // Three beats of 4 x (-125*3) = -1500 each.
    push_exp(-4500, 1'b0);
    ACC_LEN = 8'd3;
    SAT_EN  = 1'b0;
    beat(-125, 3);
    beat(-125, 3);
    chk("len3_no_early_valid", longint'(OUT_VALID), 0);
    beat(-125, 3);
    chk("len3_valid_lat", longint'(OUT_VALID), 1);
    chk("len3_data", longint'(DATA_OUT), -4500);

    // Ten beats of 64516: saturate at 2^19-1, then wrap to 645160 - 2^20.
    push_exp(524287, 1'b1);
    ACC_LEN = 8'd10;
    SAT_EN  = 1'b1;
    for (int i = 0; i < 10; i++) beat(127, 127);
    chk("sat_out_sat", longint'(OUT_SAT), 1);
    push_exp(-403416, 1'b1);
    SAT_EN = 1'b0;
    for (int i = 0; i < 10; i++) beat(127, 127);
    chk("wrap_data", longint'(DATA_OUT), -403416);

    // ACC_LEN=0 behaves as a single-beat vector.
    push_exp(-24, 1'b0);
    ACC_LEN = 8'd0;
    beat(2, -3);
    chk("len0_valid_lat", longint'(OUT_VALID), 1);
    chk("len0_data", longint'(DATA_OUT), -24);
    idle(1);

    // Backpressure: result held 5 cycles, then last beat and output handshake coincide.
    OUT_READY = 1'b0;
    push_exp(400, 1'b0);
    ACC_LEN = 8'd1;
    beat(10, 10);
    chk("bp_valid", longint'(OUT_VALID), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      chk("bp_in_ready_low", longint'(IN_READY), 0);
      chk("bp_data_stable", longint'(DATA_OUT), 400);
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    push_exp(-140, 1'b0);
    beat(5, -7);
    chk("bp_overlap_valid", longint'(OUT_VALID), 1);
    chk("bp_overlap_data", longint'(DATA_OUT), -140);
    idle(1);

    // CLR mid-vector discards two 40000 beats; a mid-vector ACC_LEN change is ignored.
    push_exp(16, 1'b0);
    ACC_LEN = 8'd4;
    beat(100, 100);
    beat(100, 100);
    CLR = 1'b1;
    @(negedge CLK);
    chk("clr_in_ready_low", longint'(IN_READY), 0);
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    beat(1, 1);
    ACC_LEN = 8'd2;
    beat(1, 1);
    chk("len_change_ignored", longint'(OUT_VALID), 0);
    beat(1, 1);
    beat(1, 1);
    chk("clr_data", longint'(DATA_OUT), 16);
    idle(1);

    // Reset mid-vector with a nonzero result still in the output register.
    ACC_LEN = 8'd4;
    beat(50, 50);
    beat(50, 50);
    SYNC_RST_B = 1'b0;
    idle(2);
    SYNC_RST_B = 1'b1;
    chk("mid_rst_out_valid", longint'(OUT_VALID), 0);
    chk("mid_rst_data_out", longint'(DATA_OUT), 0);
    chk("mid_rst_out_sat", longint'(OUT_SAT), 0);
    chk("mid_rst_in_ready", longint'(IN_READY), 1);
    push_exp(8, 1'b0);
    ACC_LEN = 8'd2;
    beat(1, 1);
    beat(1, 1);
    chk("post_rst_data", longint'(DATA_OUT), 8);

    for (int t = 0; t < 20 && sb_q.size() != 0; t++) idle(1);
    chk("sb_drained", longint'(sb_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
